// File: rtl/commit_trace_buf.sv
// commit_trace_buf: commit-trace capture unit for the RV32 single-cycle CPU.
// Logs every retired instruction (pc, instr, rf writeback) into a circular
// buffer while in RUN. It halts with a cause code on timeout, EBREAK, a fetch
// error, or a full buffer when WRAP=0. The buffer is read back by age index
// through a 1-cycle-latency read port.
//
// Optional feature macro: COMMIT_TRACE_MEM_EN. It adds the data-memory write
// tap ports cm_dm_we/cm_dm_addr/cm_dm_wdata and extends each entry with them.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, clear         control pulses (clear wins over start and commit)
//   cm_*                 retire stream tap
//   rd_en, rd_idx        read request, age index (0 = oldest)
//   rd_data, rd_valid    registered read result
//   count, cycles        stored entries, RUN-cycle counter
//   halted, halt_cause   halt flag, cause (1 timeout, 2 halt instr, 3 err, 4 full)
module commit_trace_buf #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 64,
  parameter int unsigned     MAX_CYCLES = 1000,
  parameter bit              WRAP       = 1'b1,
  parameter logic [XLEN-1:0] HALT_INSTR = XLEN'(32'h00100073),
  localparam int unsigned    AW         = $clog2(DEPTH),
  localparam int unsigned    CW         = AW + 1,
`ifdef COMMIT_TRACE_MEM_EN
  localparam int unsigned    EW         = 5*XLEN + 7
`else
  localparam int unsigned    EW         = 3*XLEN + 6
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clear,
  input  logic            cm_valid,
  input  logic [XLEN-1:0] cm_pc,
  input  logic [XLEN-1:0] cm_instr,
  input  logic            cm_err,
  input  logic            cm_rf_we,
  input  logic [4:0]      cm_rd,
  input  logic [XLEN-1:0] cm_wdata,
`ifdef COMMIT_TRACE_MEM_EN
  input  logic            cm_dm_we,
  input  logic [XLEN-1:0] cm_dm_addr,
  input  logic [XLEN-1:0] cm_dm_wdata,
`endif
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_idx,
  output logic [EW-1:0]   rd_data,
  output logic            rd_valid,
  output logic [CW-1:0]   count,
  output logic [31:0]     cycles,
  output logic            halted,
  output logic [2:0]      halt_cause
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] wr_ptr;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] entry_c;
  logic          wr_en_c;
  logic [2:0]    cause_c;
  logic [AW-1:0] oldest_c;
  logic [AW-1:0] rd_addr_c;

  // Entry packing: oldest-first field order {pc, instr, rf_we, rd, wdata[, dm]}.
`ifdef COMMIT_TRACE_MEM_EN
  assign entry_c = {cm_pc, cm_instr, cm_rf_we, cm_rd, cm_wdata,
                    cm_dm_we, cm_dm_addr, cm_dm_wdata};
`else
  assign entry_c = {cm_pc, cm_instr, cm_rf_we, cm_rd, cm_wdata};
`endif

  // Oldest slot sits count entries behind wr_ptr; when full this equals wr_ptr.
  assign oldest_c  = wr_ptr - AW'(count);
  assign rd_addr_c = oldest_c + rd_idx;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, write enable and halt cause (lowest cause number wins).
  always_comb begin
    state_d = state_q;
    wr_en_c = 1'b0;
    cause_c = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        wr_en_c = cm_valid;
        if ((MAX_CYCLES != 0) && (cycles == 32'(MAX_CYCLES - 1))) begin
          cause_c = 3'd1;
        end else if (cm_valid && (cm_instr == HALT_INSTR)) begin
          cause_c = 3'd2;
        end else if (cm_valid && cm_err) begin
          cause_c = 3'd3;
        end else if (!WRAP && cm_valid && (count == CW'(DEPTH - 1))) begin
          cause_c = 3'd4;
        end
        if (cause_c != 3'd0) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (clear) begin
      state_d = S_IDLE;
      wr_en_c = 1'b0;
      cause_c = 3'd0;
    end
  end

  // Pointers, counters, halt status and read port.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr     <= '0;
      count      <= '0;
      cycles     <= '0;
      halt_cause <= 3'd0;
      halted     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (state_q == S_RUN) begin
        cycles <= cycles + 32'd1;
      end
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count != CW'(DEPTH)) begin
          count <= count + CW'(1);
        end
      end
      if (cause_c != 3'd0) begin
        halt_cause <= cause_c;
        halted     <= 1'b1;
      end
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= (CW'(rd_idx) < count) ? mem[rd_addr_c] : '0;
      end
    end
  end

  // Storage array; not cleared, and never written in a reset cycle.
  always_ff @(posedge clk) begin
    if (wr_en_c && !rst) begin
      mem[wr_ptr] <= entry_c;
    end
  end

endmodule

// File: tb/tb_commit_trace_buf.sv
// Testbench for commit_trace_buf: three configurations share one stimulus
// stream (A: DEPTH=64/WRAP=1/MAX=1000, B: DEPTH=4/WRAP=1/no timeout,
// C: DEPTH=4/WRAP=0/no timeout) and are checked against a queue-based model.
module tb_commit_trace_buf;
  localparam int unsigned XLEN = 32;
`ifdef COMMIT_TRACE_MEM_EN
  localparam int unsigned EW = 5*XLEN + 7;
`else
  localparam int unsigned EW = 3*XLEN + 6;
`endif
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, clear, cm_valid, cm_err, cm_rf_we, rd_en;
  logic [31:0] cm_pc, cm_instr, cm_wdata;
  logic [4:0]  cm_rd;
  logic [5:0]  rd_idx;
`ifdef COMMIT_TRACE_MEM_EN
  logic        cm_dm_we;
  logic [31:0] cm_dm_addr, cm_dm_wdata;
`endif

  logic [EW-1:0] rd_data_a, rd_data_b, rd_data_c;
  logic          rd_valid_a, rd_valid_b, rd_valid_c;
  logic [6:0]    count_a;
  logic [2:0]    count_b, count_c;
  logic [31:0]   cycles_a, cycles_b, cycles_c;
  logic          halted_a, halted_b, halted_c;
  logic [2:0]    cause_a, cause_b, cause_c;

  commit_trace_buf #(.DEPTH(64), .MAX_CYCLES(1000), .WRAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .cm_valid(cm_valid),
    .cm_pc(cm_pc), .cm_instr(cm_instr), .cm_err(cm_err), .cm_rf_we(cm_rf_we),
    .cm_rd(cm_rd), .cm_wdata(cm_wdata),
`ifdef COMMIT_TRACE_MEM_EN
    .cm_dm_we(cm_dm_we), .cm_dm_addr(cm_dm_addr), .cm_dm_wdata(cm_dm_wdata),
`endif
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .count(count_a), .cycles(cycles_a), .halted(halted_a), .halt_cause(cause_a)
  );

  commit_trace_buf #(.DEPTH(4), .MAX_CYCLES(0), .WRAP(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .cm_valid(cm_valid),
    .cm_pc(cm_pc), .cm_instr(cm_instr), .cm_err(cm_err), .cm_rf_we(cm_rf_we),
    .cm_rd(cm_rd), .cm_wdata(cm_wdata),
`ifdef COMMIT_TRACE_MEM_EN
    .cm_dm_we(cm_dm_we), .cm_dm_addr(cm_dm_addr), .cm_dm_wdata(cm_dm_wdata),
`endif
    .rd_en(rd_en), .rd_idx(rd_idx[1:0]), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .count(count_b), .cycles(cycles_b), .halted(halted_b), .halt_cause(cause_b)
  );

  commit_trace_buf #(.DEPTH(4), .MAX_CYCLES(0), .WRAP(1'b0)) dut_c (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .cm_valid(cm_valid),
    .cm_pc(cm_pc), .cm_instr(cm_instr), .cm_err(cm_err), .cm_rf_we(cm_rf_we),
    .cm_rd(cm_rd), .cm_wdata(cm_wdata),
`ifdef COMMIT_TRACE_MEM_EN
    .cm_dm_we(cm_dm_we), .cm_dm_addr(cm_dm_addr), .cm_dm_wdata(cm_dm_wdata),
`endif
    .rd_en(rd_en), .rd_idx(rd_idx[1:0]), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .count(count_c), .cycles(cycles_c), .halted(halted_c), .halt_cause(cause_c)
  );

  // Per-configuration views for the randomized comparison loop.
  logic [6:0]    o_count  [3];
  logic [31:0]   o_cycles [3];
  logic          o_halted [3];
  logic [2:0]    o_cause  [3];
  logic          o_rv     [3];
  logic [EW-1:0] o_rd     [3];
  assign o_count[0]  = count_a;
  assign o_count[1]  = 7'(count_b);
  assign o_count[2]  = 7'(count_c);
  assign o_cycles[0] = cycles_a;
  assign o_cycles[1] = cycles_b;
  assign o_cycles[2] = cycles_c;
  assign o_halted[0] = halted_a;
  assign o_halted[1] = halted_b;
  assign o_halted[2] = halted_c;
  assign o_cause[0]  = cause_a;
  assign o_cause[1]  = cause_b;
  assign o_cause[2]  = cause_c;
  assign o_rv[0]     = rd_valid_a;
  assign o_rv[1]     = rd_valid_b;
  assign o_rv[2]     = rd_valid_c;
  assign o_rd[0]     = rd_data_a;
  assign o_rd[1]     = rd_data_b;
  assign o_rd[2]     = rd_data_c;

  int pass_n = 0;
  int chk_n  = 0;

  // Reference model: the trace is a queue of entries, oldest at the front.
  int unsigned   p_depth [3] = '{64, 4, 4};
  bit            p_wrap  [3] = '{1'b1, 1'b1, 1'b0};
  int unsigned   p_max   [3] = '{1000, 0, 0};
  int            m_st    [3];  // 0 idle, 1 run, 2 halt
  logic [31:0]   m_cyc   [3];
  logic [2:0]    m_cause [3];
  logic          m_rv    [3];
  logic [EW-1:0] m_rd    [3];
  logic [EW-1:0] m_q     [3][$];

  function automatic logic [EW-1:0] cur_entry();
`ifdef COMMIT_TRACE_MEM_EN
    return {cm_pc, cm_instr, cm_rf_we, cm_rd, cm_wdata, cm_dm_we, cm_dm_addr, cm_dm_wdata};
`else
    return {cm_pc, cm_instr, cm_rf_we, cm_rd, cm_wdata};
`endif
  endfunction

  function automatic logic [31:0] pc_of(logic [EW-1:0] e);
    return e[EW-1 -: 32];
  endfunction

  function automatic logic [31:0] instr_of(logic [EW-1:0] e);
    return e[EW-33 -: 32];
  endfunction

  function automatic void model_step(int k);
    int idx;
    logic [2:0] c;
    if (rst || clear) begin
      m_st[k] = 0; m_cyc[k] = '0; m_cause[k] = '0; m_rv[k] = 1'b0; m_rd[k] = '0;
      m_q[k].delete();
    end else begin
      m_rv[k] = rd_en;
      if (rd_en) begin
        idx = int'(rd_idx) % int'(p_depth[k]);
        m_rd[k] = (idx < m_q[k].size()) ? m_q[k][idx] : '0;
      end
      if (m_st[k] == 0) begin
        if (start) m_st[k] = 1;
      end else if (m_st[k] == 1) begin
        c = 3'd0;
        if (p_max[k] != 0 && m_cyc[k] == 32'(p_max[k] - 1)) c = 3'd1;
        else if (cm_valid && cm_instr == EBREAK) c = 3'd2;
        else if (cm_valid && cm_err) c = 3'd3;
        else if (!p_wrap[k] && cm_valid && m_q[k].size() == int'(p_depth[k]) - 1) c = 3'd4;
        m_cyc[k] = m_cyc[k] + 32'd1;
        if (cm_valid) begin
          if (m_q[k].size() == int'(p_depth[k])) void'(m_q[k].pop_front());
          m_q[k].push_back(cur_entry());
        end
        if (c != 3'd0) begin
          m_st[k] = 2;
          m_cause[k] = c;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; clear = 1'b0; cm_valid = 1'b0; cm_err = 1'b0;
    cm_rf_we = 1'b0; rd_en = 1'b0; cm_pc = '0; cm_instr = 32'h13; cm_wdata = '0;
    cm_rd = '0; rd_idx = '0;
`ifdef COMMIT_TRACE_MEM_EN
    cm_dm_we = 1'b0; cm_dm_addr = '0; cm_dm_wdata = '0;
`endif
  endtask

  task automatic pulse_clear_start();
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] instr);
    cm_valid = 1'b1; cm_pc = pc; cm_instr = instr; cm_rf_we = 1'b1;
    cm_rd = 5'(pc >> 2); cm_wdata = $urandom;
    tick();
    cm_valid = 1'b0; cm_instr = 32'h13;
  endtask

  task automatic read_a(input logic [5:0] idx);
    rd_en = 1'b1; rd_idx = idx; tick(); rd_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk_n++; if (count_a !== 7'd0) $display("FAIL reset_count got %0d want 0", count_a); else pass_n++;
    chk_n++; if (cycles_a !== 32'd0) $display("FAIL reset_cycles got %0d want 0", cycles_a); else pass_n++;
    chk_n++; if (halted_a !== 1'b0 || cause_a !== 3'd0)
      $display("FAIL reset_halt got %0b/%0d want 0/0", halted_a, cause_a); else pass_n++;
    chk_n++; if (rd_valid_a !== 1'b0 || rd_data_a !== '0)
      $display("FAIL reset_rd got %0b/%h want 0/0", rd_valid_a, rd_data_a); else pass_n++;
  endtask

  task automatic test_retire();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) commit(32'(4 * i), 32'h00000013 | (32'(i) << 20));
    chk_n++; if (count_a !== 7'd10) $display("FAIL retire_count got %0d want 10", count_a); else pass_n++;
    rd_en = 1'b1; rd_idx = 6'd9;
    chk_n++; if (rd_valid_a !== 1'b0) $display("FAIL retire_rv_early got %0b want 0", rd_valid_a); else pass_n++;
    tick(); rd_en = 1'b0;
    chk_n++; if (rd_valid_a !== 1'b1 || pc_of(rd_data_a) !== 32'h24)
      $display("FAIL retire_read9 got v=%0b pc=%h want v=1 pc=24", rd_valid_a, pc_of(rd_data_a)); else pass_n++;
    chk_n++; if (cycles_a !== 32'd11) $display("FAIL retire_cycles got %0d want 11", cycles_a); else pass_n++;
    read_a(6'd10);
    chk_n++; if (rd_valid_a !== 1'b1 || rd_data_a !== '0)
      $display("FAIL retire_read_oob got v=%0b d=%h want v=1 d=0", rd_valid_a, rd_data_a); else pass_n++;
  endtask

  task automatic test_wrap();
    pulse_clear_start();
    for (int i = 0; i < 6; i++) commit(32'(4 * i), 32'h13);
    chk_n++; if (count_b !== 3'd4) $display("FAIL wrap_count got %0d want 4", count_b); else pass_n++;
    chk_n++; if (halted_b !== 1'b0) $display("FAIL wrap_halted got %0b want 0", halted_b); else pass_n++;
    read_a(6'd0);
    chk_n++; if (pc_of(rd_data_b) !== 32'h08) $display("FAIL wrap_idx0 got %h want 08", pc_of(rd_data_b)); else pass_n++;
    read_a(6'd3);
    chk_n++; if (pc_of(rd_data_b) !== 32'h14) $display("FAIL wrap_idx3 got %h want 14", pc_of(rd_data_b)); else pass_n++;
  endtask

  task automatic test_stop_full();
    pulse_clear_start();
    for (int i = 0; i < 3; i++) commit(32'(4 * i), 32'h13);
    chk_n++; if (halted_c !== 1'b0) $display("FAIL full_early got %0b want 0", halted_c); else pass_n++;
    commit(32'h0c, 32'h13);
    chk_n++; if (halted_c !== 1'b1 || cause_c !== 3'd4)
      $display("FAIL full_halt got %0b/%0d want 1/4", halted_c, cause_c); else pass_n++;
    commit(32'h10, 32'h13);
    chk_n++; if (count_c !== 3'd4) $display("FAIL full_count got %0d want 4", count_c); else pass_n++;
    read_a(6'd3);
    chk_n++; if (pc_of(rd_data_c) !== 32'h0c) $display("FAIL full_idx3 got %h want 0c", pc_of(rd_data_c)); else pass_n++;
  endtask

  task automatic test_ebreak();
    pulse_clear_start();
    commit(32'h40, EBREAK);
    chk_n++; if (halted_a !== 1'b1 || cause_a !== 3'd2)
      $display("FAIL ebreak_halt got %0b/%0d want 1/2", halted_a, cause_a); else pass_n++;
    commit(32'h44, 32'h13);
    tick(); tick();
    chk_n++; if (cycles_a !== 32'd1 || count_a !== 7'd1)
      $display("FAIL ebreak_frozen got cyc=%0d cnt=%0d want 1/1", cycles_a, count_a); else pass_n++;
    read_a(6'd0);
    chk_n++; if (pc_of(rd_data_a) !== 32'h40 || instr_of(rd_data_a) !== EBREAK)
      $display("FAIL ebreak_entry got pc=%h in=%h want 40/%h", pc_of(rd_data_a), instr_of(rd_data_a), EBREAK); else pass_n++;
  endtask

  task automatic test_timeout();
    int n;
    pulse_clear_start();
    n = 0;
    while (n < 1100 && halted_a !== 1'b1) begin
      tick();
      n++;
    end
    chk_n++; if (n !== 1000) $display("FAIL timeout_ticks got %0d want 1000", n); else pass_n++;
    chk_n++; if (cycles_a !== 32'd1000 || cause_a !== 3'd1)
      $display("FAIL timeout_state got cyc=%0d cause=%0d want 1000/1", cycles_a, cause_a); else pass_n++;
  endtask

  task automatic test_priority_clear();
    pulse_clear_start();
    repeat (999) tick();
    cm_err = 1'b1;
    commit(32'h80, EBREAK);
    cm_err = 1'b0;
    chk_n++; if (cause_a !== 3'd1) $display("FAIL prio_a got %0d want 1", cause_a); else pass_n++;
    chk_n++; if (cause_b !== 3'd2 || cause_c !== 3'd2)
      $display("FAIL prio_bc got %0d/%0d want 2/2", cause_b, cause_c); else pass_n++;
    clear = 1'b1; start = 1'b1;
    commit(32'h84, 32'h13);
    clear = 1'b0; start = 1'b0;
    chk_n++; if (halted_a !== 1'b0 || count_a !== 7'd0 || cycles_a !== 32'd0 || cause_a !== 3'd0)
      $display("FAIL clear_state got h=%0b cnt=%0d cyc=%0d c=%0d want 0/0/0/0", halted_a, count_a, cycles_a, cause_a); else pass_n++;
    commit(32'h88, 32'h13);
    chk_n++; if (count_a !== 7'd0 || cycles_a !== 32'd0)
      $display("FAIL idle_ignores got cnt=%0d cyc=%0d want 0/0", count_a, cycles_a); else pass_n++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom % 250) == 0;
      clear    = ($urandom % 70) == 0;
      start    = ($urandom % 6) == 0;
      cm_valid = $urandom % 2;
      cm_err   = ($urandom % 40) == 0;
      cm_instr = (($urandom % 40) == 0) ? EBREAK : $urandom;
      cm_pc    = $urandom;
      cm_wdata = $urandom;
      cm_rd    = 5'($urandom);
      cm_rf_we = $urandom % 2;
`ifdef COMMIT_TRACE_MEM_EN
      cm_dm_we = $urandom % 2; cm_dm_addr = $urandom; cm_dm_wdata = $urandom;
`endif
      rd_en    = $urandom % 2;
      rd_idx   = ($urandom % 2) ? 6'($urandom_range(0, 15)) : 6'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        chk_n++; if (o_count[k] !== 7'(m_q[k].size()))
          $display("FAIL rnd_count[%0d] cyc %0d got %0d want %0d", k, i, o_count[k], m_q[k].size()); else pass_n++;
        chk_n++; if (o_cycles[k] !== m_cyc[k])
          $display("FAIL rnd_cycles[%0d] cyc %0d got %0d want %0d", k, i, o_cycles[k], m_cyc[k]); else pass_n++;
        chk_n++; if (o_halted[k] !== (m_st[k] == 2) || o_cause[k] !== m_cause[k])
          $display("FAIL rnd_halt[%0d] cyc %0d got %0b/%0d want %0b/%0d", k, i, o_halted[k], o_cause[k], m_st[k] == 2, m_cause[k]); else pass_n++;
        chk_n++; if (o_rv[k] !== m_rv[k] || o_rd[k] !== m_rd[k])
          $display("FAIL rnd_read[%0d] cyc %0d got %0b/%h want %0b/%h", k, i, o_rv[k], o_rd[k], m_rv[k], m_rd[k]); else pass_n++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_retire();
    test_wrap();
    test_stop_full();
    test_ebreak();
    test_timeout();
    test_priority_clear();
    test_random();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule

// File: doc/commit_trace_buf.md
Name: commit_trace_buf

Overview:
- Synthesizable commit-trace capture unit for the RV32 single-cycle CPU.
- Taps the retire stream: PC, instruction, and register-file writeback.
- Stores each retired instruction in a parametrised circular buffer.
- Detects stop conditions (cycle limit, EBREAK, error flag, buffer full) and raises a halt with a cause code.
- Sits beside the CPU in the top-level computer; the buffer is read back through a 1-cycle-latency read port for on-board debug.

Parameters:
- XLEN, 32, width of PC, instruction and writeback data.
- DEPTH, 64, number of trace entries; power of 2, minimum 4.
- MAX_CYCLES, 1000, RUN-state cycle limit; 0 disables the timeout.
- WRAP, 1, 1 = overwrite oldest when full; 0 = halt when full.
- HALT_INSTR, 32'h00100073, instruction encoding that halts the unit (EBREAK).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active high.
- start  in  1  pulse; leaves IDLE and enters RUN.
- clear  in  1  pulse; empties the buffer and returns to IDLE.
- cm_valid  in  1  an instruction retires this cycle.
- cm_pc  in  XLEN  PC of the retiring instruction.
- cm_instr  in  XLEN  encoding of the retiring instruction.
- cm_err  in  1  fetched instruction invalid or unknown.
- cm_rf_we  in  1  register write enable.
- cm_rd  in  5  destination register.
- cm_wdata  in  XLEN  writeback data.
- rd_en  in  1  read request.
- rd_idx  in  log2(DEPTH)  age index; 0 = oldest entry.
- rd_data  out  3*XLEN+6  {pc, instr, rf_we, rd, wdata} (width grows with TRACE_MEM_EN).
- rd_valid  out  1  rd_data is valid.
- count  out  log2(DEPTH)+1  number of stored entries.
- cycles  out  32  RUN-cycle counter.
- halted  out  1  unit is in HALT.
- halt_cause  out  3  0 none, 1 timeout, 2 halt instr, 3 err, 4 full.

Behaviour:
- Reset and clear:
  - rst: state=IDLE; wr_ptr, count, cycles, halt_cause, rd_valid and rd_data all 0; halted=0.
  - clear has the same effect but does not touch the storage array.
- State machine:
  - IDLE: commits are ignored; start -> RUN.
  - RUN: cycles increments by 1 every clock; a commit with cm_valid=1 writes one entry at wr_ptr, and wr_ptr advances modulo DEPTH.
  - HALT: no writes, counters frozen; only clear or rst leaves HALT, back to IDLE.
- Halt checks, evaluated on each RUN cycle:
  - cm_valid && cm_err -> cause 3.
  - cm_valid && cm_instr==HALT_INSTR -> cause 2.
  - WRAP=0 and this write makes count==DEPTH -> cause 4.
  - MAX_CYCLES!=0 and cycles==MAX_CYCLES-1 -> cause 1.
  - When several conditions hold in the same cycle, the lowest nonzero cause number wins: 1 < 2 < 3 < 4.
- Halt timing: the triggering instruction is logged in the same edge; halted=1 and halt_cause are valid the next cycle.
- Buffer full:
  - WRAP=1: the oldest entry is overwritten, count saturates at DEPTH, and the oldest pointer tracks wr_ptr.
  - WRAP=0: reaching full forces HALT, so no overwrite occurs.
- Read port:
  - Physical address = (oldest + rd_idx) mod DEPTH.
  - rd_data and rd_valid register one cycle after rd_en.
  - rd_idx >= count returns rd_data=0 with rd_valid=1.
  - Reads are legal in any state.
  - A read and a write to the same slot in the same cycle returns the old contents.
- Other boundaries:
  - start while in RUN or HALT is ignored.
  - clear has priority over start and over a commit in the same cycle.
  - rst mid-RUN aborts immediately; no partial entry is written.
  - cycles wraps at 2^32 only when MAX_CYCLES=0.

Optional Feature:
- Macro: COMMIT_TRACE_MEM_EN.
- Defined: adds ports cm_dm_we (in, 1), cm_dm_addr (in, XLEN) and cm_dm_wdata (in, XLEN). Each entry is extended with {dm_we, dm_addr, dm_wdata}, making rd_data 5*XLEN+7 bits wide.
- Undefined: those ports are absent, entries are 3*XLEN+6 bits, and no data-memory logic is built.

Test Plan:
1. Retire limit: rst, start, then 10 commits with pc=0,4,...,36 -> count=10; reading idx 9 gives pc=0x24 with rd_valid 1 cycle after rd_en.
2. Wrap: DEPTH=4, WRAP=1, 6 commits with pc=0..0x14 -> count=4; idx 0 gives pc=0x08 and idx 3 gives pc=0x14; halted=0.
3. Stop-when-full: DEPTH=4, WRAP=0, 4 commits -> halted=1 and halt_cause=4 the next cycle; a 5th commit is not stored and count stays 4.
4. EBREAK: commit of instr 0x00100073 at pc=0x40 -> the entry is logged, halt_cause=2, cycles frozen.
5. Timeout: MAX_CYCLES=1000, no commits -> halted rises with cycles=1000 and halt_cause=1.
6. Priority and clear: cm_err and HALT_INSTR asserted in the timeout cycle -> halt_cause=1; a following clear pulse gives halted=0, count=0 and state IDLE.
